// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: memory-op encodings,
// bus size codes, the LSU state enum and small op-decoding helpers.
package mips_defs_pkg;

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsuState_e;

  // Stores occupy the top three encodings.
  function automatic logic isStoreOp(input logic [2:0] op);
    return (op >= OP_SB);
  endfunction

  function automatic logic [1:0] sizeOf(input logic [2:0] op);
    logic [1:0] sz;
    case (op)
      OP_LB, OP_LBU, OP_SB: sz = SIZE_BYTE;
      OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
      default:              sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// SRAM-like data bus between the LSU (master) and the memory side (slave).
interface mem_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: bus size/direction from the op, store-data lane
// replication, and load-data extraction with sign/zero extension.
module lsu_align
  import mips_defs_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] storeData,
  input  logic [31:0] busRdata,
  output logic [1:0]  size,
  output logic        isWrite,
  output logic [31:0] laneData,
  output logic [31:0] loadData
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  // Size, direction and replicated store lanes.
  always_comb begin
    size     = sizeOf(op);
    isWrite  = isStoreOp(op);
    laneData = storeData;
    case (size)
      SIZE_BYTE: laneData = {4{storeData[7:0]}};
      SIZE_HALF: laneData = {2{storeData[15:0]}};
      default:   laneData = storeData;
    endcase
  end

  // Pick the addressed byte/half out of the bus word and extend it.
  always_comb begin
    selByte  = busRdata[{off, 3'b000} +: 8];
    selHalf  = off[1] ? busRdata[31:16] : busRdata[15:0];
    loadData = busRdata;
    case (op)
      OP_LB:   loadData = {{24{selByte[7]}}, selByte};
      OP_LBU:  loadData = {24'd0, selByte};
      OP_LH:   loadData = {{16{selHalf[15]}}, selHalf};
      OP_LHU:  loadData = {16'd0, selHalf};
      default: loadData = busRdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit driving a single-outstanding req/addr_ok/data_ok
// bus. Optional macro LSU_ALIGN_CHECK_EN: when defined, misaligned half/word
// accesses raise adel_o/ades_o and are not issued; when undefined, the low
// address bits are forced to natural alignment and no error is reported.
//
// state | meaning
// IDLE  | no access in flight; a valid MEM op issues its request here
// REQ   | request raised, waiting for the address phase to be accepted
// WAIT  | address accepted, waiting for the data phase
// DONE  | access finished, result held until the pipeline advances
module mem_lsu
  import mips_defs_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int MEMOP_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               memen,
  input  logic [MEMOP_W-1:0] memop,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [31:0]        wdata,
  input  logic               pipe_stall,
  input  logic               flush,
  output logic               stall_o,
  output logic [31:0]        rdata_o,
  output logic               adel_o,
  output logic               ades_o,
  mem_lsu_if.master          bus
);

  lsuState_e         state;
  logic              drop;
  logic [2:0]        opLat;
  logic [ADDR_W-1:0] addrLat;
  logic [31:0]       wdataLat;

  logic [2:0]        opIn;
  logic              exc;
  logic [ADDR_W-1:0] alignedAddr;
  logic              inIdle;
  logic              go;
  logic [2:0]        curOp;
  logic [ADDR_W-1:0] curAddr;
  logic [31:0]       curWdata;
  logic [31:0]       loadData;
  logic [1:0]        busSize;
  logic              busWr;
  logic [31:0]       laneData;
  logic              dropNow;

  assign opIn = memop[2:0];

`ifdef LSU_ALIGN_CHECK_EN
  // Misaligned half/word accesses are reported instead of issued.
  always_comb begin
    exc = 1'b0;
    case (opIn)
      OP_LH, OP_LHU, OP_SH: exc = addr[0];
      OP_LW, OP_SW:         exc = |addr[1:0];
      default:              exc = 1'b0;
    endcase
  end

  assign alignedAddr = addr;
`else
  assign exc = 1'b0;

  // Without error reporting, round the address down to natural alignment.
  always_comb begin
    alignedAddr = addr;
    case (sizeOf(opIn))
      SIZE_HALF: alignedAddr[0]   = 1'b0;
      SIZE_WORD: alignedAddr[1:0] = 2'b00;
      default:   alignedAddr      = addr;
    endcase
  end
`endif

  assign adel_o = memen & exc & ~isStoreOp(opIn);
  assign ades_o = memen & exc &  isStoreOp(opIn);

  assign inIdle = (state == IDLE);
  assign go     = inIdle & memen & ~exc & ~flush;

  // In IDLE the bus sees the live MEM-stage op; afterwards the held copies,
  // so the request stays stable even if the pipeline inputs move.
  assign curOp    = inIdle ? opIn        : opLat;
  assign curAddr  = inIdle ? alignedAddr : addrLat;
  assign curWdata = inIdle ? wdata       : wdataLat;

  lsu_align uAlign (
    .op        (curOp),
    .off       (curAddr[1:0]),
    .storeData (curWdata),
    .busRdata  (bus.data_rdata),
    .size      (busSize),
    .isWrite   (busWr),
    .laneData  (laneData),
    .loadData  (loadData)
  );

  assign bus.data_req   = go | (state == REQ);
  assign bus.data_wr    = busWr;
  assign bus.data_size  = busSize;
  assign bus.data_addr  = curAddr;
  assign bus.data_wdata = laneData;

  // A flush arriving this cycle discards the in-flight result just like a
  // flush remembered in drop.
  assign dropNow = drop | flush;

  assign stall_o = (go | (state == REQ) | (state == WAIT)) & ~drop & ~flush;

  // Access sequencing, drop tracking, held request copies and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      drop     <= 1'b0;
      opLat    <= 3'd0;
      addrLat  <= '0;
      wdataLat <= 32'd0;
      rdata_o  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (go) begin
            opLat    <= opIn;
            addrLat  <= alignedAddr;
            wdataLat <= wdata;
            if (bus.data_addr_ok && bus.data_data_ok) begin
              state <= DONE;
              if (!isStoreOp(opIn)) rdata_o <= loadData;
            end else if (bus.data_addr_ok) begin
              state <= WAIT;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) drop <= 1'b1;
          if (bus.data_addr_ok) begin
            if (bus.data_data_ok) begin
              if (dropNow) begin
                state <= IDLE;
                drop  <= 1'b0;
              end else begin
                state <= DONE;
                if (!isStoreOp(opLat)) rdata_o <= loadData;
              end
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) drop <= 1'b1;
          if (bus.data_data_ok) begin
            if (dropNow) begin
              state <= IDLE;
              drop  <= 1'b0;
            end else begin
              state <= DONE;
              if (!isStoreOp(opLat)) rdata_o <= loadData;
            end
          end
        end
        DONE: begin
          if (!pipe_stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a table of single-cycle accesses plus
// hand-written multi-cycle, misalignment, flush and reset sequences.
module tb_mem_lsu;
  import mips_defs_pkg::*;

  logic        clk;
  logic        rst;
  logic        memen;
  logic [2:0]  memop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        pipe_stall;
  logic        flush;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        adel_o;
  logic        ades_o;

  int nChecks = 0;
  int nFails  = 0;

  mem_lsu_if #(.ADDR_W(32)) bus ();

  mem_lsu #(.ADDR_W(32), .MEMOP_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .memen      (memen),
    .memop      (memop),
    .addr       (addr),
    .wdata      (wdata),
    .pipe_stall (pipe_stall),
    .flush      (flush),
    .stall_o    (stall_o),
    .rdata_o    (rdata_o),
    .adel_o     (adel_o),
    .ades_o     (ades_o),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] busR;
    logic [31:0] expR;
    logic [31:0] expWdata;
    logic [1:0]  expSize;
    logic        expWr;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    memen            = 1'b0;
    flush            = 1'b0;
    pipe_stall       = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'd0;
  endtask

  logic [31:0] expR;

  initial begin
    vecs[0] = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        SIZE_WORD, 1'b0};
    vecs[1] = '{OP_LB,  32'h101, 32'h0,        32'h11228344, 32'hFFFFFF83, 32'h0,        SIZE_BYTE, 1'b0};
    vecs[2] = '{OP_LBU, 32'h102, 32'h0,        32'h11228344, 32'h00000022, 32'h0,        SIZE_BYTE, 1'b0};
    vecs[3] = '{OP_LH,  32'h102, 32'h0,        32'h9ABC1234, 32'hFFFF9ABC, 32'h0,        SIZE_HALF, 1'b0};
    vecs[4] = '{OP_LHU, 32'h100, 32'h0,        32'h9ABC8234, 32'h00008234, 32'h0,        SIZE_HALF, 1'b0};
    vecs[5] = '{OP_SB,  32'h303, 32'h000000A5, 32'h77777777, 32'h00008234, 32'hA5A5A5A5, SIZE_BYTE, 1'b1};
    vecs[6] = '{OP_SH,  32'h202, 32'h1234ABCD, 32'h77777777, 32'h00008234, 32'hABCDABCD, SIZE_HALF, 1'b1};
    vecs[7] = '{OP_SW,  32'h304, 32'hCAFEF00D, 32'h77777777, 32'h00008234, 32'hCAFEF00D, SIZE_WORD, 1'b1};
    vecs[8] = '{OP_LH,  32'h200, 32'h0,        32'h0000F00F, 32'hFFFFF00F, 32'h0,        SIZE_HALF, 1'b0};
    vecs[9] = '{OP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        SIZE_WORD, 1'b0};

    rst   = 1'b0;
    memop = OP_LW;
    addr  = 32'h0;
    wdata = 32'h0;
    idleInputs();
    #3;
    chk("reset rdata_o", rdata_o, 32'h0);
    chk("reset stall_o", {31'd0, stall_o}, 32'h0);
    chk("reset data_req", {31'd0, bus.data_req}, 32'h0);
    chk("reset adel_o", {31'd0, adel_o}, 32'h0);
    #10 rst = 1'b1;
    nextCycle();

    // Table: one-cycle accesses with addr_ok and data_ok together.
    for (int i = 0; i < 10; i++) begin
      memen            = 1'b1;
      memop            = vecs[i].op;
      addr             = vecs[i].addr;
      wdata            = vecs[i].wdata;
      bus.data_addr_ok = 1'b1;
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = vecs[i].busR;
      #1;
      chk($sformatf("v%0d stall issue", i), {31'd0, stall_o}, 32'h1);
      chk($sformatf("v%0d data_req", i), {31'd0, bus.data_req}, 32'h1);
      chk($sformatf("v%0d data_wr", i), {31'd0, bus.data_wr}, {31'd0, vecs[i].expWr});
      chk($sformatf("v%0d data_size", i), {30'd0, bus.data_size}, {30'd0, vecs[i].expSize});
      chk($sformatf("v%0d data_addr", i), bus.data_addr, vecs[i].addr);
      if (vecs[i].expWr)
        chk($sformatf("v%0d data_wdata", i), bus.data_wdata, vecs[i].expWdata);
      nextCycle();
      idleInputs();
      #1;
      chk($sformatf("v%0d stall done", i), {31'd0, stall_o}, 32'h0);
      chk($sformatf("v%0d rdata_o", i), rdata_o, vecs[i].expR);
      nextCycle();
    end

    // LB 0x103: addr_ok on the second request cycle, data_ok three cycles on.
    memen = 1'b1; memop = OP_LB; addr = 32'h103;
    #1;
    chk("lb stall c1", {31'd0, stall_o}, 32'h1);
    chk("lb req c1", {31'd0, bus.data_req}, 32'h1);
    nextCycle();
    addr = 32'hFFFF_FFF0;
    bus.data_addr_ok = 1'b1;
    #1;
    chk("lb req held", {31'd0, bus.data_req}, 32'h1);
    chk("lb addr held", bus.data_addr, 32'h103);
    chk("lb stall c2", {31'd0, stall_o}, 32'h1);
    nextCycle();
    bus.data_addr_ok = 1'b0;
    addr = 32'h103;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("lb wait req", {31'd0, bus.data_req}, 32'h0);
      chk("lb wait stall", {31'd0, stall_o}, 32'h1);
      nextCycle();
    end
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h80FF0011;
    #1;
    chk("lb stall data", {31'd0, stall_o}, 32'h1);
    nextCycle();
    bus.data_data_ok = 1'b0;
    pipe_stall = 1'b1;
    #1;
    chk("lb stall done", {31'd0, stall_o}, 32'h0);
    chk("lb rdata_o", rdata_o, 32'hFFFFFF80);
    nextCycle();
    #1;
    chk("lb done hold req", {31'd0, bus.data_req}, 32'h0);
    chk("lb done hold rdata", rdata_o, 32'hFFFFFF80);
    pipe_stall = 1'b0;
    memen = 1'b0;
    nextCycle();

    memen = 1'b1; memop = OP_LBU; addr = 32'h103;
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h80FF0011;
    nextCycle();
    idleInputs();
    #1;
    chk("lbu rdata_o", rdata_o, 32'h00000080);
    nextCycle();
    expR = 32'h00000080;

    // Misaligned LW 0x101.
    memen = 1'b1; memop = OP_LW; addr = 32'h101;
    #1;
`ifdef LSU_ALIGN_CHECK_EN
    chk("mis adel_o", {31'd0, adel_o}, 32'h1);
    chk("mis data_req", {31'd0, bus.data_req}, 32'h0);
    chk("mis stall_o", {31'd0, stall_o}, 32'h0);
    memop = OP_SW;
    #1;
    chk("mis ades_o", {31'd0, ades_o}, 32'h1);
    nextCycle();
    memen = 1'b0;
    #1;
    chk("mis still idle", {31'd0, bus.data_req}, 32'h0);
    nextCycle();
`else
    chk("mis adel_o", {31'd0, adel_o}, 32'h0);
    chk("mis data_addr", bus.data_addr, 32'h100);
    chk("mis data_req", {31'd0, bus.data_req}, 32'h1);
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h13572468;
    nextCycle();
    idleInputs();
    #1;
    chk("mis rdata_o", rdata_o, 32'h13572468);
    nextCycle();
    expR = 32'h13572468;
`endif

    // Flush while waiting for data: result discarded, back to IDLE.
    memen = 1'b1; memop = OP_LW; addr = 32'h100;
    bus.data_addr_ok = 1'b1;
    nextCycle();
    bus.data_addr_ok = 1'b0;
    flush = 1'b1;
    nextCycle();
    flush = 1'b0;
    memen = 1'b0;
    #1;
    chk("flush stall drop", {31'd0, stall_o}, 32'h0);
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h00000055;
    nextCycle();
    idleInputs();
    #1;
    chk("flush rdata kept", rdata_o, expR);
    chk("flush stall idle", {31'd0, stall_o}, 32'h0);
    memen = 1'b1; memop = OP_LW; addr = 32'h100;
    #1;
    chk("flush idle req", {31'd0, bus.data_req}, 32'h1);
    chk("flush idle stall", {31'd0, stall_o}, 32'h1);
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h2468ACE0;
    nextCycle();
    idleInputs();
    #1;
    chk("post flush rdata", rdata_o, 32'h2468ACE0);
    nextCycle();

    // Asynchronous reset in the middle of WAIT.
    memen = 1'b1; memop = OP_LW; addr = 32'h400;
    bus.data_addr_ok = 1'b1;
    nextCycle();
    bus.data_addr_ok = 1'b0;
    memen = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("arst rdata_o", rdata_o, 32'h0);
    chk("arst data_req", {31'd0, bus.data_req}, 32'h0);
    chk("arst stall_o", {31'd0, stall_o}, 32'h0);
    #1 rst = 1'b1;
    nextCycle();
    memen = 1'b1; memop = OP_LW; addr = 32'h400;
    #1;
    chk("post rst req", {31'd0, bus.data_req}, 32'h1);
    bus.data_addr_ok = 1'b1; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h0BADF00D;
    nextCycle();
    idleInputs();
    #1;
    chk("post rst rdata", rdata_o, 32'h0BADF00D);
    chk("post rst stall", {31'd0, stall_o}, 32'h0);
    nextCycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
